// File: rtl/rns_pkg.sv
// rns_pkg: shared state encoding and channel helpers
// for the sequential CRT converter.
package rns_pkg;

   typedef enum logic [2:0] {
      IDLE,
      MPROD,
      QPROD,
      ACC,
      FIN,
      OUT
   } state_t;

   // Accept edge to out_valid, counting the accept edge itself.
   function automatic int crt_latency(input int n);
      return n + n * (n + 1) + 2;
   endfunction

   function automatic int ch_lo(input int i, input int w);
      return i * w;
   endfunction

   function automatic int ch_hi(input int i, input int w);
      return ch_lo(i, w) + w - 1;
   endfunction

endpackage

// File: rtl/crt_term_unit.sv
// crt_term_unit: combinational CRT term x = (c*A) mod m,
// shared by all channels of the converter.
module crt_term_unit #(
   parameter int MOD_SIZE = 5
) (
   input  logic [MOD_SIZE-1:0] i_c,
   input  logic [MOD_SIZE-1:0] i_a,
   input  logic [MOD_SIZE-1:0] i_m,
   output logic [MOD_SIZE-1:0] o_x
);

   localparam int PW = 2 * MOD_SIZE;

   logic [PW-1:0] w_p;
   logic [PW-1:0] w_r;

   assign w_p = PW'(i_c) * PW'(i_a);

   // Zero modulus only appears on rejected bundles.
   assign w_r = (i_m == '0) ? '0 : (w_p % PW'(i_m));

   assign o_x = MOD_SIZE'(w_r);

endmodule

// File: rtl/rns2bin_crt_seq.sv
// rns2bin_crt_seq: sequential CRT RNS-to-binary converter,
// one shared multiply per cycle, valid/ready on both sides.
module rns2bin_crt_seq
   import rns_pkg::*;
#(
   parameter int MOD_NUM  = 4,
   parameter int MOD_SIZE = 5,
   parameter int RANGE    = MOD_NUM * MOD_SIZE,
   parameter bit SIGNED   = 1'b1
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic [MOD_NUM*MOD_SIZE-1:0] mods,
   input  logic [MOD_NUM*MOD_SIZE-1:0] invs,
   input  logic [MOD_NUM*MOD_SIZE-1:0] res,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic [RANGE:0]              n_out,
   output logic                        err
);

   localparam int CW = (MOD_NUM > 1) ? $clog2(MOD_NUM) : 1;

   state_t r_state;
   state_t w_next;

   logic [MOD_SIZE-1:0] w_mod [MOD_NUM];
   logic [MOD_SIZE-1:0] w_inv [MOD_NUM];
   logic [MOD_SIZE-1:0] w_res [MOD_NUM];

   logic [MOD_SIZE-1:0] r_mod [MOD_NUM];
   logic [MOD_SIZE-1:0] r_inv [MOD_NUM];
   logic [MOD_SIZE-1:0] r_res [MOD_NUM];

   logic [RANGE-1:0]    r_m;
   logic [RANGE-1:0]    r_q;
   logic [RANGE:0]      r_s;
   logic [RANGE:0]      r_n;
   logic [CW-1:0]       r_k;
   logic [CW-1:0]       r_i;
   logic                r_err;

   logic                w_accept;
   logic                w_bad;
   logic                w_last_k;
   logic                w_last_i;
   logic [MOD_SIZE-1:0] w_x;
   logic [RANGE-1:0]    w_mul_a;
   logic [MOD_SIZE-1:0] w_mul_b;
   logic [RANGE-1:0]    w_term;
   logic [RANGE:0]      w_sum;
   logic [RANGE:0]      w_acc;
   logic [RANGE-1:0]    w_half;
   logic [RANGE:0]      w_fin;

   always_comb begin
      w_bad = 1'b0;
      for (int j = 0; j < MOD_NUM; j++) begin
         w_mod[j] = mods[ch_lo(j, MOD_SIZE) +: MOD_SIZE];
         w_inv[j] = invs[ch_lo(j, MOD_SIZE) +: MOD_SIZE];
         w_res[j] = res[ch_lo(j, MOD_SIZE) +: MOD_SIZE];
         if (w_mod[j] < MOD_SIZE'(2) || w_res[j] >= w_mod[j])
            w_bad = 1'b1;
      end
   end

   assign in_ready  = (r_state == IDLE);
   assign out_valid = (r_state == OUT);
   assign n_out     = r_n;
   assign err       = r_err;

   assign w_accept = in_valid & in_ready;
   assign w_last_k = (r_k == CW'(MOD_NUM - 1));
   assign w_last_i = (r_i == CW'(MOD_NUM - 1));

   crt_term_unit #(
      .MOD_SIZE (MOD_SIZE)
   ) u_term (
      .i_c (r_res[r_i]),
      .i_a (r_inv[r_i]),
      .i_m (r_mod[r_i]),
      .o_x (w_x)
   );

   // Single multiplier: M product, Q product, or x_i*Q.
   always_comb begin
      w_mul_a = r_q;
      w_mul_b = (r_k == r_i) ? MOD_SIZE'(1) : r_mod[r_k];
      unique case (r_state)
         MPROD: begin
            w_mul_a = r_m;
            w_mul_b = r_mod[r_k];
         end
         ACC: begin
            w_mul_a = r_q;
            w_mul_b = w_x;
         end
         default: ;
      endcase
   end

   assign w_term = w_mul_a * RANGE'(w_mul_b);
   assign w_sum  = r_s + {1'b0, w_term};
   assign w_acc  = (w_sum >= {1'b0, r_m}) ?
                   (w_sum - {1'b0, r_m}) : w_sum;
   assign w_half = (r_m - RANGE'(1)) >> 1;

   always_comb begin
      w_fin = r_s;
      if (r_err)
         w_fin = '0;
      else if (SIGNED && (r_s > {1'b0, w_half}))
         w_fin = r_s - {1'b0, r_m};
   end

   always_ff @(posedge clk) begin
      if (reset)
         r_state <= IDLE;
      else
         r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         IDLE:
            if (w_accept)
               w_next = w_bad ? FIN : MPROD;
         MPROD:
            if (w_last_k)
               w_next = QPROD;
         QPROD:
            if (w_last_k)
               w_next = ACC;
         ACC:
            w_next = w_last_i ? FIN : QPROD;
         FIN:
            w_next = OUT;
         OUT:
            if (out_ready)
               w_next = IDLE;
         default:
            w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int j = 0; j < MOD_NUM; j++) begin
            r_mod[j] <= '0;
            r_inv[j] <= '0;
            r_res[j] <= '0;
         end
         r_m   <= '0;
         r_q   <= '0;
         r_s   <= '0;
         r_n   <= '0;
         r_k   <= '0;
         r_i   <= '0;
         r_err <= 1'b0;
      end else begin
         unique case (r_state)
            IDLE:
               if (w_accept) begin
                  for (int j = 0; j < MOD_NUM; j++) begin
                     r_mod[j] <= w_mod[j];
                     r_inv[j] <= w_inv[j];
                     r_res[j] <= w_res[j];
                  end
                  r_m   <= RANGE'(1);
                  r_q   <= RANGE'(1);
                  r_s   <= '0;
                  r_k   <= '0;
                  r_i   <= '0;
                  r_err <= w_bad;
               end
            MPROD: begin
               r_m <= w_term;
               r_k <= w_last_k ? '0 : r_k + 1'b1;
               if (w_last_k)
                  r_q <= RANGE'(1);
            end
            QPROD: begin
               r_q <= w_term;
               r_k <= w_last_k ? '0 : r_k + 1'b1;
            end
            ACC: begin
               r_s <= w_acc;
               r_q <= RANGE'(1);
               if (!w_last_i)
                  r_i <= r_i + 1'b1;
            end
            FIN:
               r_n <= w_fin;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_rns2bin_crt_seq.sv
// tb_rns2bin_crt_seq: directed checks of unsigned, signed
// and 3-channel converters against hand-computed results.
module tb_rns2bin_crt_seq;

   logic        clk;
   logic        reset;

   logic        in_valid;
   logic        out_ready;
   logic [19:0] mods;
   logic [19:0] invs;
   logic [19:0] res;

   logic        u_in_ready;
   logic        u_out_valid;
   logic [20:0] u_n;
   logic        u_err;

   logic        s_in_ready;
   logic        s_out_valid;
   logic [20:0] s_n;
   logic        s_err;

   logic        t_in_valid;
   logic        t_out_ready;
   logic [14:0] t_mods;
   logic [14:0] t_invs;
   logic [14:0] t_res;
   logic        t_in_ready;
   logic        t_out_valid;
   logic [15:0] t_n;
   logic        t_err;

   int n_cmp;
   int n_fail;

   rns2bin_crt_seq #(
      .MOD_NUM  (4),
      .MOD_SIZE (5),
      .SIGNED   (1'b0)
   ) u_uns (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (u_in_ready),
      .mods      (mods),
      .invs      (invs),
      .res       (res),
      .out_valid (u_out_valid),
      .out_ready (out_ready),
      .n_out     (u_n),
      .err       (u_err)
   );

   rns2bin_crt_seq #(
      .MOD_NUM  (4),
      .MOD_SIZE (5),
      .SIGNED   (1'b1)
   ) u_sgn (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (s_in_ready),
      .mods      (mods),
      .invs      (invs),
      .res       (res),
      .out_valid (s_out_valid),
      .out_ready (out_ready),
      .n_out     (s_n),
      .err       (s_err)
   );

   rns2bin_crt_seq #(
      .MOD_NUM  (3),
      .MOD_SIZE (5),
      .SIGNED   (1'b0)
   ) u_m3 (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (t_in_valid),
      .in_ready  (t_in_ready),
      .mods      (t_mods),
      .invs      (t_invs),
      .res       (t_res),
      .out_valid (t_out_valid),
      .out_ready (t_out_ready),
      .n_out     (t_n),
      .err       (t_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag,
                      input logic [63:0] obs,
                      input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h",
                tag, obs, exp);
      end
   endtask

   // Accept one bundle on both 4-channel converters,
   // scramble the inputs, then check result and latency.
   task automatic conv4(input string       tag,
                        input logic [19:0] r,
                        input logic [20:0] eu,
                        input logic [20:0] es,
                        input logic        ee,
                        input int          lat);
      int cyc;
      chk({tag, ".in_ready"}, u_in_ready & s_in_ready, 1);
      res      = r;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      res      = '1;
      cyc      = 1;
      while (!u_out_valid && cyc < 100) begin
         @(posedge clk);
         #1;
         cyc++;
      end
      chk({tag, ".lat"}, cyc, lat);
      chk({tag, ".s_valid"}, s_out_valid, 1);
      chk({tag, ".u_n"}, u_n, eu);
      chk({tag, ".u_err"}, u_err, ee);
      chk({tag, ".s_n"}, s_n, es);
      chk({tag, ".s_err"}, s_err, ee);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      chk({tag, ".drop"}, u_out_valid | s_out_valid, 0);
      chk({tag, ".idle"}, u_in_ready, 1);
   endtask

   initial begin
      int cyc;
      int hi;
      n_cmp       = 0;
      n_fail      = 0;
      reset       = 1'b1;
      in_valid    = 1'b0;
      out_ready   = 1'b0;
      mods        = {5'd15, 5'd13, 5'd11, 5'd7};
      invs        = {5'd11, 5'd6, 5'd1, 5'd5};
      res         = '0;
      t_in_valid  = 1'b0;
      t_out_ready = 1'b0;
      t_mods      = {5'd7, 5'd5, 5'd3};
      t_invs      = {5'd1, 5'd1, 5'd2};
      t_res       = {5'd2, 5'd3, 5'd2};

      repeat (3) @(posedge clk);
      #1;
      chk("rst.in_ready", u_in_ready, 1);
      chk("rst.out_valid", u_out_valid, 0);
      chk("rst.err", u_err, 0);
      chk("rst.n_out", u_n, 0);
      chk("rst.s_n_out", s_n, 0);
      reset = 1'b0;
      @(posedge clk);
      #1;

      conv4("v1000", {5'd10, 5'd12, 5'd10, 5'd6},
            21'd1000, 21'd1000, 1'b0, 26);
      conv4("vneg1", {5'd14, 5'd12, 5'd10, 5'd6},
            21'd15014, 21'h1FFFFF, 1'b0, 26);
      conv4("vneg7507", {5'd8, 5'd7, 5'd6, 5'd4},
            21'd7508, 21'h1FFFFF - 21'd7506, 1'b0, 26);
      conv4("vpos7507", {5'd7, 5'd6, 5'd5, 5'd3},
            21'd7507, 21'd7507, 1'b0, 26);
      conv4("vzero", 20'd0, 21'd0, 21'd0, 1'b0, 26);
      conv4("err_res", {5'd10, 5'd12, 5'd10, 5'd7},
            21'd0, 21'd0, 1'b1, 2);
      mods = {5'd15, 5'd13, 5'd1, 5'd7};
      conv4("err_mod", {5'd10, 5'd12, 5'd0, 5'd6},
            21'd0, 21'd0, 1'b1, 2);
      mods = {5'd15, 5'd13, 5'd11, 5'd7};

      // Hold in OUT with a new bundle already offered.
      res      = {5'd10, 5'd12, 5'd10, 5'd6};
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      res = {5'd8, 5'd7, 5'd6, 5'd4};
      cyc = 1;
      while (!u_out_valid && cyc < 100) begin
         @(posedge clk);
         #1;
         cyc++;
      end
      chk("hold.lat", cyc, 26);
      for (int k = 0; k < 5; k++) begin
         chk("hold.n_out", u_n, 21'd1000);
         chk("hold.in_ready", u_in_ready, 0);
         chk("hold.out_valid", u_out_valid, 1);
         @(posedge clk);
         #1;
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      chk("b2b.idle", u_in_ready, 1);
      chk("b2b.drop", u_out_valid, 0);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      res      = '1;
      cyc      = 1;
      while (!u_out_valid && cyc < 100) begin
         @(posedge clk);
         #1;
         cyc++;
      end
      chk("b2b.lat", cyc, 26);
      chk("b2b.u_n", u_n, 21'd7508);
      chk("b2b.s_n", s_n, 21'h1FFFFF - 21'd7506);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;

      // Abort a conversion at its tenth cycle.
      res      = {5'd10, 5'd12, 5'd10, 5'd6};
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (9) @(posedge clk);
      #1;
      chk("abort.busy", u_in_ready, 0);
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      chk("abort.in_ready", u_in_ready, 1);
      chk("abort.out_valid", u_out_valid, 0);
      chk("abort.n_out", u_n, 0);
      chk("abort.err", u_err, 0);
      hi = 0;
      repeat (40) begin
         @(posedge clk);
         #1;
         if (u_out_valid || s_out_valid)
            hi++;
      end
      chk("abort.no_valid", hi, 0);
      conv4("post_abort", {5'd7, 5'd6, 5'd5, 5'd3},
            21'd7507, 21'd7507, 1'b0, 26);

      // Three-channel instance.
      chk("m3.in_ready", t_in_ready, 1);
      t_in_valid = 1'b1;
      @(posedge clk);
      #1;
      t_in_valid = 1'b0;
      t_res      = '1;
      cyc        = 1;
      while (!t_out_valid && cyc < 100) begin
         @(posedge clk);
         #1;
         cyc++;
      end
      chk("m3.lat", cyc, 17);
      chk("m3.n_out", t_n, 16'd23);
      chk("m3.err", t_err, 0);
      t_out_ready = 1'b1;
      @(posedge clk);
      #1;
      t_out_ready = 1'b0;
      chk("m3.drop", t_out_valid, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/rns2bin_crt_seq.md
# rns2bin_crt_seq

Sequential, parametrised RNS-to-binary converter using the Chinese Remainder Theorem, with a valid/ready handshake on both sides. It accepts MOD_NUM residues together with their moduli and precomputed CRT inverses. It produces the reconstructed value modulo M, or optionally its signed (centred) form. It sits after the RNS arithmetic datapath and replaces the fixed 4-channel combinational converter. Its operating point is one multiply per cycle, so it scales to any channel count.

## Interface
- MOD_NUM, 4: number of moduli/channels (≥2).
- MOD_SIZE, 5: bit width of each modulus, residue and inverse.
- RANGE, MOD_NUM*MOD_SIZE: width of M and of the unsigned result.
- SIGNED, 1: 1 maps the result into [-(M-1)/2, (M-1)/2]; 0 gives [0, M-1].
- clk  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- in_valid  in  1  input bundle valid.
- in_ready  out  1  block can accept a bundle.
- mods  in  MOD_NUM*MOD_SIZE  moduli; channel i is at [i*MOD_SIZE +: MOD_SIZE].
- invs  in  MOD_NUM*MOD_SIZE  A_i = (M/m_i)^-1 mod m_i, packed as for mods.
- res  in  MOD_NUM*MOD_SIZE  residues c_i, packed as for mods.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- n_out  out  RANGE+1  result: two's complement if SIGNED, otherwise zero-extended.
- err  out  1  the bundle was invalid; qualified by out_valid.

## Operation
- FSM states: IDLE, MPROD, QPROD, ACC, FIN, OUT.
- IDLE: in_ready=1. A transfer occurs when in_valid & in_ready. On transfer, capture mods, invs and res into registers.
  - Validity check at capture: error if any m_i<2 or any c_i≥m_i.
  - On error: go to FIN with err flagged. Otherwise go to MPROD.
- MPROD: MOD_NUM cycles. M starts at 1; M ← M*m_k for k=0..MOD_NUM-1. Multiply width is RANGE × MOD_SIZE, truncated to RANGE bits (the product cannot overflow).
- Per channel i, for i=0..MOD_NUM-1:
  - QPROD: MOD_NUM cycles. Q starts at 1; Q ← Q*(k==i ? 1 : m_k).
  - ACC: 1 cycle.
    - x_i = (c_i*A_i) mod m_i, computed on 2*MOD_SIZE bits.
    - s ← s + x_i*Q. Because x_i*Q < M, at most one conditional subtract of M is needed: if the sum ≥ M, subtract M.
  - The accumulator s is RANGE+1 bits wide and is cleared on capture.
- FIN: 1 cycle.
  - If err: n_out=0.
  - Else if SIGNED and s > (M-1)>>1: n_out = s − M, sign-extended.
  - Else n_out = s.
  - Go to OUT.
- OUT: out_valid=1. n_out and err are held stable until out_ready. On out_valid & out_ready, go to IDLE.
- The block does not check that the moduli are pairwise coprime or that the inverses are correct. Bad moduli or inverses give an undefined value with err=0.

## Timing
- Reset values: state=IDLE, in_ready=1, out_valid=0, err=0, n_out=0. Internal M, Q and s are cleared.
- Latency from the accept edge to out_valid rising is MOD_NUM + MOD_NUM*(MOD_NUM+1) + 2 cycles. This is 26 cycles for MOD_NUM=4. An error bundle takes 2 cycles.
- in_ready=0 in every state except IDLE. There is no input buffering and a single bundle is in flight.
- The earliest back-to-back case is out_ready=1 on the first OUT cycle. The next accept then occurs one cycle later, in IDLE; IDLE never overlaps OUT.
- Inputs are sampled only on the accept edge. Changes to inputs during the computation are ignored.
- Reset asserted in any state aborts the computation on that edge. The next cycle shows reset values, and a pending out_valid is dropped.

## Structure
- Package rns_pkg holds:
  - the state enum;
  - a latency function of MOD_NUM;
  - pack/unpack helper functions for channel fields.
- One sub-module: crt_term_unit. It is combinational, computes x_i = (c_i*A_i) mod m_i, and is instantiated once, shared across channels.

## Test plan
Baseline for all scenarios: MOD_NUM=4, moduli {7,11,13,15}, inverses {5,1,6,11}, M=15015.
- Residues {6,10,12,10}, SIGNED=0 → n_out=1000, err=0, out_valid exactly 26 cycles after accept.
- SIGNED=1, residues {6,10,12,14} → n_out=−1 (all ones); residues {4,6,7,8} → −7507; residues for 7507 → +7507; residues {0,0,0,0} → 0.
- Residue 7 on modulus 7, or modulus 1 → err=1, n_out=0, out_valid 2 cycles after accept.
- Hold out_ready=0 for 5 cycles in OUT → n_out stable, in_ready=0, nothing accepted; then a back-to-back second bundle converts correctly.
- Assert reset at cycle 10 of a conversion → out_valid never rises; in_ready=1 on the next cycle; a new bundle converts correctly.
- MOD_NUM=3 with moduli {3,5,7} and inverses {2,1,1}, residues {2,3,2} → n_out=23 (SIGNED=0), latency 17.
